// File: rtl/rst_sequencer_pkg.sv
// Shared types and defaults for the reset sequencer.
package rst_sequencer_pkg;

  typedef enum logic [2:0] {
    StWaitLock   = 3'd0,
    StLockStable = 3'd1,
    StDdrReset   = 3'd2,
    StWaitCalib  = 3'd3,
    StRun        = 3'd4,
    StFail       = 3'd5
  } seq_state_e;

  localparam int unsigned LockCyclesDefault   = 1024;
  localparam int unsigned DdrRstCyclesDefault = 256;
  localparam int unsigned CalibTimeoutDefault = 1048576;
  localparam int unsigned MaxRetryDefault     = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; resets to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// PLL-lock / DDR-calibration reset sequencer with registered reset outputs.
// Define RST_SEQUENCER_RETRY_EN to retry DDR reset after calibration timeouts.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES    = LockCyclesDefault,
  parameter int unsigned DDR_RST_CYCLES = DdrRstCyclesDefault,
  parameter int unsigned CALIB_TIMEOUT  = CalibTimeoutDefault,
  parameter int unsigned MAX_RETRY      = MaxRetryDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       calib_done,
  output logic       ddr_rst,
  output logic       user_rst,
  output logic [2:0] seq_state,
  output logic [1:0] retry_cnt,
  output logic       fail
);

  localparam int unsigned MaxCycles = max3(LOCK_CYCLES, DDR_RST_CYCLES, CALIB_TIMEOUT);
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] LockLast  = CntW'(LOCK_CYCLES - 1);
  localparam logic [CntW-1:0] DdrLast   = CntW'(DDR_RST_CYCLES - 1);
  localparam logic [CntW-1:0] CalibLast = CntW'(CALIB_TIMEOUT - 1);

`ifdef RST_SEQUENCER_RETRY_EN
  localparam logic RetryEn = 1'b1;
`else
  localparam logic RetryEn = 1'b0;
`endif

  logic [1:0] sync_q;
  logic       lock_s;
  logic       calib_s;

  sync_2ff #(
    .WIDTH(2)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  ({pll_lock, calib_done}),
    .q  (sync_q)
  );

  assign lock_s  = sync_q[1];
  assign calib_s = sync_q[0];

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      retry_q, retry_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    unique case (state_q)
      StWaitLock: if (lock_s) state_d = StLockStable;
      StLockStable: begin
        if (cnt_q == LockLast) state_d = StDdrReset;
        else cnt_d = cnt_q + 1'b1;
      end
      StDdrReset: begin
        if (cnt_q == DdrLast) state_d = StWaitCalib;
        else cnt_d = cnt_q + 1'b1;
      end
      StWaitCalib: begin
        if (calib_s) begin
          state_d = StRun;
        end else if (cnt_q == CalibLast) begin
          if (RetryEn && (32'(retry_q) < MAX_RETRY)) begin
            state_d = StDdrReset;
            retry_d = retry_q + 2'd1;
          end else begin
            state_d = StFail;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: if (!calib_s) state_d = StDdrReset;
      StFail: state_d = StFail;
      default: state_d = StWaitLock;
    endcase
    // Lock loss overrides any same-cycle calibration or timeout decision.
    if (!lock_s && (state_q != StWaitLock) && (state_q != StFail)) begin
      state_d = StWaitLock;
      retry_d = retry_q;
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StWaitLock;
      cnt_q    <= '0;
      retry_q  <= '0;
      ddr_rst  <= 1'b1;
      user_rst <= 1'b1;
      fail     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      ddr_rst  <= (state_d == StWaitLock) || (state_d == StLockStable) ||
                  (state_d == StDdrReset) || (state_d == StFail);
      user_rst <= (state_d != StRun);
      fail     <= (state_d == StFail);
    end
  end

  assign seq_state = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with small cycle parameters.
module tb_rst_sequencer;
  import rst_sequencer_pkg::*;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       calib_done;
  logic       ddr_rst;
  logic       user_rst;
  logic [2:0] seq_state;
  logic [1:0] retry_cnt;
  logic       fail;

  int checks = 0;
  int errors = 0;

  rst_sequencer #(
    .LOCK_CYCLES   (8),
    .DDR_RST_CYCLES(4),
    .CALIB_TIMEOUT (16),
    .MAX_RETRY     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pll_lock  (pll_lock),
    .calib_done(calib_done),
    .ddr_rst   (ddr_rst),
    .user_rst  (user_rst),
    .seq_state (seq_state),
    .retry_cnt (retry_cnt),
    .fail      (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns the number of negedges until seq_state first equals s.
  task automatic wait_state(input logic [2:0] s, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (seq_state !== s && n < bound);
  endtask

  // Counts consecutive cycles spent in s, and how many of them had ddr_rst high.
  task automatic count_state(input logic [2:0] s, input int bound, output int n,
                             output int ddr_hi);
    n = 0;
    ddr_hi = 0;
    while (seq_state === s && n < bound) begin
      n++;
      if (ddr_rst === 1'b1) ddr_hi++;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int hi;
    logic [1:0] exp_retry;

    // Power-on reset values
    rst = 1'b1;
    pll_lock = 1'b1;
    calib_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", seq_state, 0);
    check("rst_ddr_rst", ddr_rst, 1);
    check("rst_user_rst", user_rst, 1);
    check("rst_retry", retry_cnt, 0);
    check("rst_fail", fail, 0);

    // Normal bring-up
    rst = 1'b0;
    wait_state(3'd1, 20, n);
    check("up_lock_latency", n, 3);
    count_state(3'd1, 40, n, hi);
    check("up_lock_cycles", n, 8);
    count_state(3'd2, 40, n, hi);
    check("up_ddr_cycles", n, 4);
    check("up_ddr_high", hi, 4);
    check("up_calib_state", seq_state, 3);
    check("up_ddr_fell", ddr_rst, 0);
    check("up_user_held", user_rst, 1);
    repeat (5) @(negedge clk);
    calib_done = 1'b1;
    wait_state(3'd4, 20, n);
    check("up_user_latency", n, 3);
    check("up_user_rst", user_rst, 0);
    check("up_run_ddr", ddr_rst, 0);

    // Lock glitch during qualification forces full requalification
    calib_done = 1'b0;
    apply_reset();
    wait_state(3'd1, 20, n);
    check("gl_lock_latency", n, 3);
    repeat (5) @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    wait_state(3'd0, 20, n);
    check("gl_back_to_wait", n, 2);
    count_state(3'd0, 20, n, hi);
    check("gl_wait_cycles", n, 1);
    count_state(3'd1, 40, n, hi);
    check("gl_requal_cycles", n, 8);

    // Calibration never completes
    count_state(3'd2, 40, n, hi);
    check("to_ddr_cycles", n, 4);
    count_state(3'd3, 60, n, hi);
    check("to_calib_cycles", n, 16);
    check("to_calib_ddr_low", hi, 0);
`ifdef RST_SEQUENCER_RETRY_EN
    for (int i = 1; i <= 3; i++) begin
      check("to_retry_state", seq_state, 2);
      check("to_retry_cnt", retry_cnt, i);
      count_state(3'd2, 40, n, hi);
      check("to_retry_ddr", n, 4);
      count_state(3'd3, 60, n, hi);
      check("to_retry_calib", n, 16);
    end
    check("to_final_retry", retry_cnt, 3);
`else
    check("to_final_retry", retry_cnt, 0);
`endif
    check("to_fail_state", seq_state, 5);
    check("to_fail_flag", fail, 1);
    check("to_fail_ddr", ddr_rst, 1);
    check("to_fail_user", user_rst, 1);
    count_state(3'd5, 6, n, hi);
    check("to_fail_sticky", n, 6);

    // Asynchronous reset out of FAIL, checked before the next rising edge
    #2;
    rst = 1'b1;
    #1;
    check("ar_state", seq_state, 0);
    check("ar_fail", fail, 0);
    check("ar_retry", retry_cnt, 0);
    check("ar_ddr", ddr_rst, 1);
    check("ar_user", user_rst, 1);
    @(negedge clk);
    rst = 1'b0;

    // Calibration loss and lock loss while running
    apply_reset();
`ifdef RST_SEQUENCER_RETRY_EN
    wait_state(3'd3, 40, n);
    wait_state(3'd2, 40, n);
    calib_done = 1'b1;
    exp_retry = 2'd1;
`else
    calib_done = 1'b1;
    exp_retry = 2'd0;
`endif
    wait_state(3'd4, 60, n);
    check("rn_in_run", seq_state, 4);
    check("rn_retry", retry_cnt, exp_retry);
    calib_done = 1'b0;
    wait_state(3'd2, 20, n);
    check("rn_calib_loss", n, 3);
    check("rn_calib_user", user_rst, 1);
    check("rn_calib_retry", retry_cnt, exp_retry);
    calib_done = 1'b1;
    wait_state(3'd4, 30, n);
    check("rn_rerun", seq_state, 4);
    pll_lock = 1'b0;
    wait_state(3'd0, 20, n);
    check("rn_lock_loss", n, 3);
    check("rn_lock_ddr", ddr_rst, 1);
    check("rn_lock_user", user_rst, 1);
    check("rn_lock_retry", retry_cnt, exp_retry);

    // Lock loss on the same cycle as the calibration timeout
    pll_lock = 1'b1;
    calib_done = 1'b0;
    apply_reset();
    wait_state(3'd3, 40, n);
    repeat (13) @(negedge clk);
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    check("tie_still_calib", seq_state, 3);
    @(negedge clk);
    check("tie_state", seq_state, 0);
    check("tie_retry", retry_cnt, 0);
    check("tie_fail", fail, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
